// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge detector with binary/magnitude output
module sobel_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Mode,
    input  logic [DATA_W-1:0] Threshold,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              DataValid,
    output logic              isReady,
    output logic              Dop,
    output logic [DATA_W-1:0] Gradient,
    output logic              Finish,
    output logic [CNT_W-1:0]  Out_Row,
    output logic [CNT_W-1:0]  Out_Column,
    output logic [1:0]        current_state
);

    localparam int GW = DATA_W + 4;
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_finish;
    logic               r_drain;
    logic [CNT_W-1:0]   r_row;
    logic [CNT_W-1:0]   r_col;
    logic               r_mode;
    logic [DATA_W-1:0]  r_thr;

    logic [DATA_W-1:0]  r_lb0 [IMG_W];
    logic [DATA_W-1:0]  r_lb1 [IMG_W];
    logic [DATA_W-1:0]  r_win [3][2];

    logic               r_v1;
    logic [GW-1:0]      r_mag;
    logic               r_dop;
    logic [DATA_W-1:0]  r_grad;

    logic               w_accept;
    logic               w_col_wrap;
    logic               w_last;
    logic               w_win_valid;
    logic [AW-1:0]      w_idx;
    logic [DATA_W-1:0]  w_p [3][3];
    logic signed [GW-1:0] w_gx;
    logic signed [GW-1:0] w_gy;
    logic [GW-1:0]      w_abs_gx;
    logic [GW-1:0]      w_abs_gy;
    logic [GW-1:0]      w_mag;
    logic [DATA_W-1:0]  w_sat;
    logic [DATA_W-1:0]  w_bin;

    function automatic logic [GW-1:0] ext(input logic [DATA_W-1:0] v);
        return GW'(v);
    endfunction

    assign w_accept    = r_ready & DataValid;
    assign w_col_wrap  = (r_col == CNT_W'(IMG_W - 1));
    assign w_last      = w_accept && w_col_wrap && (r_row == CNT_W'(IMG_H - 1));
    assign w_win_valid = w_accept && (r_row >= CNT_W'(2)) && (r_col >= CNT_W'(2));
    assign w_idx       = r_col[AW-1:0];

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b0;
            r_finish <= 1'b0;
            r_drain  <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
            r_mode   <= 1'b0;
            r_thr    <= '0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_mode  <= Mode;
                        r_thr   <= Threshold;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_col_wrap) begin
                            r_col <= '0;
                            r_row <= r_row + CNT_W'(1);
                        end else begin
                            r_col <= r_col + CNT_W'(1);
                        end
                        if (w_last) begin
                            r_state <= S_DRAIN;
                            r_ready <= 1'b0;
                            r_drain <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        r_state  <= S_DONE;
                        r_finish <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Column 2 of the window is the live pixel plus the two line-buffer taps.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_p[i][0] = r_win[i][0];
            w_p[i][1] = r_win[i][1];
        end
        w_p[0][2] = r_lb0[w_idx];
        w_p[1][2] = r_lb1[w_idx];
        w_p[2][2] = DataIn;
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_lb0[w_idx] <= r_lb1[w_idx];
            r_lb1[w_idx] <= DataIn;
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= w_p[i][2];
            end
        end
    end

    assign w_gx = (ext(w_p[0][2]) + (ext(w_p[1][2]) << 1) + ext(w_p[2][2]))
                - (ext(w_p[0][0]) + (ext(w_p[1][0]) << 1) + ext(w_p[2][0]));
    assign w_gy = (ext(w_p[2][0]) + (ext(w_p[2][1]) << 1) + ext(w_p[2][2]))
                - (ext(w_p[0][0]) + (ext(w_p[0][1]) << 1) + ext(w_p[0][2]));
    assign w_abs_gx = w_gx[GW-1] ? GW'(-w_gx) : GW'(w_gx);
    assign w_abs_gy = w_gy[GW-1] ? GW'(-w_gy) : GW'(w_gy);
    assign w_mag    = w_abs_gx + w_abs_gy;

    assign w_sat = (r_mag > ext({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : r_mag[DATA_W-1:0];
    assign w_bin = (r_mag >= ext(r_thr)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_v1   <= 1'b0;
            r_mag  <= '0;
            r_dop  <= 1'b0;
            r_grad <= '0;
        end else begin
            r_v1  <= w_win_valid;
            r_dop <= r_v1;
            if (w_win_valid) begin
                r_mag <= w_mag;
            end
            if (r_v1) begin
                r_grad <= r_mode ? w_sat : w_bin;
            end
        end
    end

    assign isReady       = r_ready;
    assign Dop           = r_dop;
    assign Gradient      = r_grad;
    assign Finish        = r_finish;
    assign Out_Row       = r_row;
    assign Out_Column    = r_col;
    assign current_state = r_state;

endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - randomized self-checking bench for sobel_stream
module tb_sobel_stream;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          Reset_n = 1'b1;
    logic          Start = 1'b0;
    logic          Mode = 1'b0;
    logic [DW-1:0] Threshold = '0;
    logic [DW-1:0] DataIn = '0;
    logic          DataValid = 1'b0;
    logic          isReady;
    logic          Dop;
    logic [DW-1:0] Gradient;
    logic          Finish;
    logic [CW-1:0] Out_Row;
    logic [CW-1:0] Out_Column;
    logic [1:0]    current_state;

    int            n_checks = 0;
    int            n_pass = 0;
    int            img [H][W];
    logic [DW-1:0] last_grad = '0;

    sobel_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Mode(Mode),
        .Threshold(Threshold), .DataIn(DataIn), .DataValid(DataValid),
        .isReady(isReady), .Dop(Dop), .Gradient(Gradient), .Finish(Finish),
        .Out_Row(Out_Row), .Out_Column(Out_Column), .current_state(current_state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic fill(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0: img[r][c] = 100;
                    1: img[r][c] = (c >= 2) ? 10 : 0;
                    2: img[r][c] = (c >= 2) ? 100 : 0;
                    default: img[r][c] = int'($urandom_range(0, 255));
                endcase
    endtask

    // 3x3 neighbourhood whose newest pixel is img[r][c]
    function automatic logic [DW-1:0] ref_grad(input logic mode, input logic [DW-1:0] thr,
                                               input int r, input int c);
        int gx, gy, mag;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mode) return (mag > 255) ? 8'hFF : mag[7:0];
        return (mag >= int'(thr)) ? 8'hFF : 8'h00;
    endfunction

    task automatic check_cleared(input string tag);
        chk({tag, "_isReady"}, isReady, 0);
        chk({tag, "_Dop"}, Dop, 0);
        chk({tag, "_Finish"}, Finish, 0);
        chk({tag, "_Gradient"}, Gradient, 0);
        chk({tag, "_Out_Row"}, Out_Row, 0);
        chk({tag, "_Out_Column"}, Out_Column, 0);
        chk({tag, "_state"}, current_state, 0);
    endtask

    task automatic run_frame(input logic mode, input logic [DW-1:0] thr, input int gap_pct,
                             input int start_len, input int mid_start, input int abort_at);
        int            acc = 0;
        int            last_n = -1;
        int            n = 0;
        bit            done = 0;
        bit            run;
        int            dop_n[$];
        logic [DW-1:0] expq[$];
        while (!done) begin
            @(negedge CLK);
            run = (n > 0) && (acc < W*H);
            chk("isReady", isReady, run);
            if (run) begin
                chk("Out_Row", Out_Row, acc / W);
                chk("Out_Column", Out_Column, acc % W);
                chk("state_run", current_state, 1);
            end
            if (n == 0) chk("state_idle", current_state, 0);
            if (dop_n.size() > 0 && dop_n[0] == n) begin
                chk("Dop", Dop, 1);
                void'(dop_n.pop_front());
                last_grad = expq.pop_front();
                chk("Gradient", Gradient, last_grad);
            end else begin
                chk("Dop_low", Dop, 0);
                chk("Gradient_hold", Gradient, last_grad);
            end
            chk("Finish", Finish, (last_n >= 0 && n == last_n + 3));
            if (last_n >= 0)
                chk("state_tail", current_state,
                    (n <= last_n + 2) ? 2 : (n == last_n + 3) ? 3 : 0);
            if (abort_at > 0 && acc == abort_at) begin
                #2 Reset_n = 1'b0;
                #1 check_cleared("abort");
                Start = 1'b0;
                DataValid = 1'b0;
                repeat (3) begin
                    @(negedge CLK);
                    chk("abort_Dop", Dop, 0);
                    chk("abort_Finish", Finish, 0);
                end
                Reset_n = 1'b1;
                last_grad = '0;
                return;
            end
            Start = (n < start_len) || (n == mid_start);
            if (n < start_len) begin
                Mode = mode;
                Threshold = thr;
            end else begin
                Mode = 1'($urandom_range(0, 1));
                Threshold = DW'($urandom_range(0, 255));
            end
            DataValid = ($urandom_range(0, 99) >= gap_pct);
            DataIn = (acc < W*H) ? DW'(img[acc / W][acc % W]) : DW'($urandom_range(0, 255));
            if (run && DataValid) begin
                if (acc / W >= 2 && acc % W >= 2) begin
                    dop_n.push_back(n + 2);
                    expq.push_back(ref_grad(mode, thr, acc / W, acc % W));
                end
                acc++;
                if (acc == W*H) last_n = n;
            end
            n++;
            if (last_n >= 0 && n > last_n + 4) done = 1;
            if (n > 300) begin
                chk("timeout", 0, 1);
                done = 1;
            end
        end
        Start = 1'b0;
        DataValid = 1'b0;
    endtask

    initial begin
        #3 Reset_n = 1'b0;
        #1 check_cleared("reset");
        repeat (2) @(negedge CLK);
        Reset_n = 1'b1;

        fill(0); run_frame(1'b1, 8'd0, 0, 1, -1, 0);
        fill(1); run_frame(1'b1, 8'd0, 0, 1, -1, 0);
        run_frame(1'b0, 8'd50, 0, 1, -1, 0);
        run_frame(1'b0, 8'd40, 0, 1, -1, 0);
        fill(2); run_frame(1'b1, 8'd0, 0, 1, -1, 0);
        fill(3); run_frame(1'b1, 8'd0, 0, 1, -1, 0);
        run_frame(1'b1, 8'd0, 40, 1, -1, 0);
        run_frame(1'b0, 8'd128, 30, 2, 7, 0);
        fill(2); run_frame(1'b1, 8'd0, 20, 1, -1, 9);
        fill(0); run_frame(1'b1, 8'd0, 0, 1, -1, 0);
        for (int k = 0; k < 4; k++) begin
            fill(3);
            run_frame(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), 25, 1, -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Parameters
REQ-001 The block SHALL take parameter DATA_W, default 8, meaning pixel, threshold and gradient width in bits.
REQ-002 The block SHALL take parameter IMG_W, default 8, meaning frame width in pixels; legal range is 3 or more.
REQ-003 The block SHALL take parameter IMG_H, default 8, meaning frame height in pixels; legal range is 3 or more.
REQ-004 The block SHALL take parameter CNT_W, default 8, meaning the width of the row and column counters; the value must satisfy 2^CNT_W > max(IMG_W, IMG_H).

Interface
REQ-005 CLK  in  1  sole clock; all state changes on the rising edge.
REQ-006 Reset_n  in  1  asynchronous, active-low reset.
REQ-007 Start  in  1  single-cycle frame start request.
REQ-008 Mode  in  1  output mode: 0 = binary threshold, 1 = saturated magnitude.
REQ-009 Threshold  in  DATA_W  comparison threshold for Mode 0.
REQ-010 DataIn  in  DATA_W  input pixel, in raster order.
REQ-011 DataValid  in  1  DataIn is valid this cycle.
REQ-012 isReady  out  1  block accepts a pixel this cycle.
REQ-013 Dop  out  1  Gradient is valid this cycle.
REQ-014 Gradient  out  DATA_W  output pixel.
REQ-015 Finish  out  1  one-cycle frame-complete pulse.
REQ-016 Out_Row, Out_Column  out  CNT_W each  row and column of the next pixel to be accepted.
REQ-017 current_state  out  2  FSM state encoding.

Function
REQ-018 The FSM SHALL have four states: IDLE=0, RUN=1, DRAIN=2, DONE=3.
REQ-019 FSM transitions:
- IDLE -> RUN on Start.
- RUN -> DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1).
- DRAIN -> DONE after exactly 2 cycles.
- DONE -> IDLE unconditionally.
REQ-020 isReady SHALL equal 1 only in RUN; a pixel is accepted on a rising edge where isReady=1 and DataValid=1.
REQ-021 Start SHALL be ignored outside IDLE.
REQ-022 Mode and Threshold SHALL be captured on the Start edge and held constant for the whole frame.
REQ-023 Out_Column SHALL increment on each accepted pixel and wrap to 0 after IMG_W-1; Out_Row SHALL increment on each column wrap.
REQ-024 Out_Row and Out_Column SHALL clear to 0 on Start.
REQ-025 The block SHALL hold two line buffers of IMG_W x DATA_W plus a 3x3 shift window.
REQ-026 The window SHALL advance only on accepted pixels; idle gaps (DataValid=0) SHALL not disturb the window or the pipeline.
REQ-027 Window naming: p[i][j], i=0 is the oldest row, j=0 is the oldest column; the pixel accepted at (r,c) is p[2][2].
REQ-028 A window SHALL be valid iff the pixel accepted at (r,c) satisfies r>=2 and c>=2.
REQ-029 Only interior pixels SHALL be output: exactly (IMG_H-2)*(IMG_W-2) Dop pulses per frame, with no padding.
REQ-030 Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20), signed, DATA_W+4 bits.
REQ-031 Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02), signed, DATA_W+4 bits.
REQ-032 The magnitude SHALL be |Gx|+|Gy|, unsigned, DATA_W+4 bits, with no overflow.
REQ-033 Mode 1: Gradient = min(magnitude, 2^DATA_W - 1).
REQ-034 Mode 0: Gradient = all ones if magnitude >= Threshold, else 0.
REQ-035 The pipeline SHALL be 2 stages: Dop and Gradient are registered and appear 2 cycles after the accepting edge of a valid window.
REQ-036 Gradient SHALL hold its last value while Dop=0.
REQ-037 Finish SHALL be 1 only in DONE, one cycle after the final Dop.
REQ-038 A DataValid pixel with isReady=0 SHALL be dropped and not counted.

Reset
REQ-039 Reset_n=0 SHALL immediately force the following, regardless of clock: state IDLE, isReady=0, Dop=0, Finish=0, Gradient=0, Out_Row=0, Out_Column=0, pipeline valid bits=0.
REQ-040 Line-buffer contents need not be reset; stale data SHALL never reach Gradient, because window validity restarts from (0,0).
REQ-041 Reset mid-frame SHALL abort the frame with no further Dop or Finish; the next Start SHALL begin a clean frame.

Verification (IMG_W=IMG_H=4, DATA_W=8)
REQ-042 Flat frame of all 100s, Mode 1 -> 4 Dop pulses with Gradient=0, Finish 1 cycle after the 4th Dop, then state IDLE.
REQ-043 Columns 0-1 = 0, columns 2-3 = 10, Mode 1 -> Gradient 40,40,40,40; Mode 0 with Threshold=50 -> 0,0,0,0; Mode 0 with Threshold=40 -> 255 x4.
REQ-044 Columns 2-3 = 100, Mode 1 -> magnitude 400 saturates to 255 x4.
REQ-045 Random DataValid gaps during a frame -> identical Gradient sequence to the gap-free run; each Dop occurs exactly 2 cycles after its accepting edge.
REQ-046 Reset_n pulsed low after 9 pixels -> outputs clear asynchronously, no Finish; a new Start with the flat frame passes REQ-042.
REQ-047 Start asserted during RUN -> ignored; Start held for 2 cycles in IDLE -> exactly one frame.
